// File: rtl/jpeg_rle_encoder.sv
// JPEG AC/DC run-length symbol encoder.
// Turns zig-zag coefficients into (run, size, amp) symbols with ZRL and EOB.
module jpeg_rle_encoder #(
    parameter int COEF_W    = 12,
    parameter int BLOCK_LEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_run,
    output logic [3:0]        out_size,
    output logic [COEF_W-1:0] out_amp,
    output logic              out_dc,
    output logic              out_eob,
    output logic              out_zrl
);

    localparam int IW = $clog2(BLOCK_LEN);
    localparam logic [IW-1:0] LAST = IW'(BLOCK_LEN - 1);

    typedef enum logic {RUN, ZRL} state_t;

    typedef struct packed {
        logic [3:0]        run;
        logic [3:0]        size;
        logic [COEF_W-1:0] amp;
        logic              dc;
        logic              eob;
        logic              zrl;
    } sym_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [5:0]      run_q, run_d;
    logic [1:0]      zrl_q, zrl_d;
    sym_t            held_q, held_d;
    sym_t            out_q, out_d;
    logic            ov_q, ov_d;

    logic [COEF_W:0] mag;
    logic [COEF_W:0] vm1;
    logic [3:0]      c_size;
    logic [COEF_W-1:0] c_amp;
    logic            accept;
    logic            drain;

    assign in_ready = rst_n && (state_q == RUN) && (!ov_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = ov_q && out_ready;

    assign out_valid = ov_q;
    assign out_run   = out_q.run;
    assign out_size  = out_q.size;
    assign out_amp   = out_q.amp;
    assign out_dc    = out_q.dc;
    assign out_eob   = out_q.eob;
    assign out_zrl   = out_q.zrl;

    // Negative amplitudes use the one's-complement form: low size bits of v-1.
    always_comb begin
        mag = in_coef[COEF_W-1] ? -{in_coef[COEF_W-1], in_coef}
                                : {1'b0, in_coef};
        vm1 = {in_coef[COEF_W-1], in_coef} - {{COEF_W{1'b0}}, 1'b1};
        c_size = '0;
        for (int i = 0; i <= COEF_W; i++) begin
            if (mag[i]) c_size = 4'(i + 1);
        end
        c_amp = '0;
        for (int i = 0; i < COEF_W; i++) begin
            c_amp[i] = in_coef[COEF_W-1] ? ((i < int'(c_size)) && vm1[i])
                                         : in_coef[i];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        run_d   = run_q;
        zrl_d   = zrl_q;
        held_d  = held_q;
        out_d   = out_q;
        ov_d    = ov_q;
        if (drain) begin
            ov_d  = 1'b0;
            out_d = '0;
        end
        if (state_q == ZRL) begin
            if (drain) begin
                ov_d = 1'b1;
                if (zrl_q != 2'd0) begin
                    out_d     = '0;
                    out_d.run = 4'd15;
                    out_d.zrl = 1'b1;
                    zrl_d     = zrl_q - 2'd1;
                end else begin
                    out_d   = held_q;
                    state_d = RUN;
                end
            end
        end else if (accept) begin
            idx_d = (idx_q == LAST) ? '0 : idx_q + IW'(1);
            run_d = '0;
            if (idx_q == '0) begin
                ov_d       = 1'b1;
                out_d      = '0;
                out_d.size = c_size;
                out_d.amp  = c_amp;
                out_d.dc   = 1'b1;
            end else if (in_coef == '0) begin
                if (idx_q == LAST) begin
                    ov_d      = 1'b1;
                    out_d     = '0;
                    out_d.eob = 1'b1;
                end else begin
                    run_d = run_q + 6'd1;
                end
            end else if (run_q < 6'd16) begin
                ov_d       = 1'b1;
                out_d      = '0;
                out_d.run  = run_q[3:0];
                out_d.size = c_size;
                out_d.amp  = c_amp;
            end else begin
                ov_d        = 1'b1;
                out_d       = '0;
                out_d.run   = 4'd15;
                out_d.zrl   = 1'b1;
                zrl_d       = run_q[5:4] - 2'd1;
                held_d      = '0;
                held_d.run  = run_q[3:0];
                held_d.size = c_size;
                held_d.amp  = c_amp;
                state_d     = ZRL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            idx_q   <= '0;
            run_q   <= '0;
            zrl_q   <= '0;
            held_q  <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            zrl_q   <= zrl_d;
            held_q  <= held_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_jpeg_rle_encoder.sv
// Scoreboard bench for jpeg_rle_encoder.
// A small reference model queues expected symbols as coefficients are accepted.
module tb_jpeg_rle_encoder;

    localparam int W = 12;
    localparam int L = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_coef = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [3:0]   out_run;
    logic [3:0]   out_size;
    logic [W-1:0] out_amp;
    logic         out_dc;
    logic         out_eob;
    logic         out_zrl;

    typedef struct packed {
        logic [3:0]   run;
        logic [3:0]   size;
        logic [W-1:0] amp;
        logic         dc;
        logic         eob;
        logic         zrl;
    } sym_t;

    sym_t q[$];
    sym_t cur;
    int   total = 0;
    int   bad = 0;
    int   coefs[L];
    int   lowcnt;

    jpeg_rle_encoder #(.COEF_W(W), .BLOCK_LEN(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_run(out_run), .out_size(out_size), .out_amp(out_amp),
        .out_dc(out_dc), .out_eob(out_eob), .out_zrl(out_zrl)
    );

    always #5 clk = ~clk;

    assign cur = {out_run, out_size, out_amp, out_dc, out_eob, out_zrl};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic sym_t mk(int v, int run, bit dc);
        sym_t r;
        int a;
        int s;
        a = (v < 0) ? -v : v;
        s = 0;
        while ((1 << s) <= a) s++;
        r = '0;
        r.run  = 4'(run);
        r.size = 4'(s);
        r.amp  = (v > 0) ? W'(v) : W'((v - 1) & ((1 << s) - 1));
        r.dc   = dc;
        return r;
    endfunction

    function automatic sym_t mk_flag(bit eob);
        sym_t r;
        r = '0;
        if (eob) r.eob = 1'b1;
        else begin
            r.run = 4'd15;
            r.zrl = 1'b1;
        end
        return r;
    endfunction

    task automatic clear_block();
        for (int i = 0; i < L; i++) coefs[i] = 0;
    endtask

    // mode 0: always ready, 1: toggling, 2: random
    task automatic run_block(input int mode, input int abort_at,
                             input int watch);
        int  k = 0;
        int  cyc = 0;
        int  mrun = 0;
        bit  stalled = 0;
        bit  counting = 0;
        sym_t prev = '0;
        lowcnt = 0;
        while ((k < L || q.size() != 0) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = cyc[0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            in_valid = (k < L);
            in_coef  = (k < L) ? W'(coefs[k]) : '0;
            #1;
            if (counting) begin
                if (!in_ready) lowcnt++;
                else counting = 0;
            end
            if (stalled) chk("hold", cur, prev);
            if (out_valid) begin
                if (out_ready) begin
                    if (q.size() == 0) chk("extra", out_valid, 0);
                    else chk("sym", cur, q.pop_front());
                end
            end else begin
                chk("idle", cur, 0);
            end
            stalled = out_valid && !out_ready;
            prev = cur;
            if (in_valid && in_ready) begin
                if (k == 0) begin
                    q.push_back(mk(coefs[0], 0, 1));
                    mrun = 0;
                end else if (coefs[k] == 0) begin
                    if (k == L - 1) q.push_back(mk_flag(1));
                    else mrun++;
                end else begin
                    while (mrun >= 16) begin
                        q.push_back(mk_flag(0));
                        mrun -= 16;
                    end
                    q.push_back(mk(coefs[k], mrun, 0));
                    mrun = 0;
                end
                if (k == watch) counting = 1;
                k++;
                if (k == abort_at) break;
            end
        end
        if (abort_at > L) begin
            chk("accepted", k, L);
            chk("drained", q.size(), 0);
            for (int t = 0; t < 3; t++) begin
                @(negedge clk);
                out_ready = 1'b1;
                in_valid  = 1'b0;
                #1;
                chk("tail", out_valid, 0);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_fields", cur, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", in_ready, 1);

        clear_block();
        coefs[0] = -3;
        coefs[1] = 5;
        run_block(0, 999, -1);

        clear_block();
        coefs[34] = -1;
        run_block(0, 999, 34);
        chk("ready_low", lowcnt, 2);

        clear_block();
        run_block(0, 999, -1);

        clear_block();
        coefs[63] = 1;
        run_block(0, 999, -1);

        clear_block();
        coefs[34] = -1;
        run_block(1, 999, -1);

        clear_block();
        coefs[0]  = -2048;
        coefs[1]  = 2047;
        coefs[20] = -2048;
        coefs[54] = 1;
        run_block(2, 999, -1);

        clear_block();
        coefs[34] = -1;
        out_ready = 1'b0;
        run_block(0, 35, -1);
        @(negedge clk);
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", in_ready, 0);
        @(negedge clk);
        #1;
        chk("mid_rst_valid", out_valid, 0);
        rst_n = 1'b1;
        q.delete();
        #1;
        chk("mid_rel_ready", in_ready, 1);
        clear_block();
        coefs[0] = 7;
        run_block(0, 999, -1);

        for (int b = 0; b < 3; b++) begin
            clear_block();
            for (int i = 0; i < L; i++) begin
                if ($urandom_range(0, 9) == 0)
                    coefs[i] = int'($urandom_range(0, 4094)) - 2047;
            end
            run_block(2, 999, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
